// File: rtl/sipo_shift_register.sv
// sipo_shift_register: serial-in/parallel-out shifter with serial tap-out, fill count and full flag
// Ports: CLK rising-edge clock; Reset sync active-low; D serial in;
//        Q parallel word; SO bit shifted out; Full word framed; Count bits captured (saturating)
module sipo_shift_register #(
  parameter int WIDTH      = 4,
  parameter bit SHIFT_LEFT = 1'b1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       D,
  output logic [WIDTH-1:0]           Q,
  output logic                       SO,
  output logic                       Full,
  output logic [$clog2(WIDTH+1)-1:0] Count
);
  localparam int CW = $clog2(WIDTH+1);
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  always_comb begin
    q_d    = SHIFT_LEFT ? {q_q[WIDTH-2:0], D} : {D, q_q[WIDTH-1:1]};
    so_d   = SHIFT_LEFT ? q_q[WIDTH-1] : q_q[0];
    // full_q already marks cnt_q == WIDTH, so it doubles as the saturation guard
    cnt_d  = full_q ? cnt_q : cnt_q + CW'(1);
    full_d = (cnt_d == CW'(WIDTH));
  end
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      q_q    <= '0;
      so_q   <= 1'b0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      so_q   <= so_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end
  assign Q     = q_q;
  assign SO    = so_q;
  assign Full  = full_q;
  assign Count = cnt_q;
endmodule

// File: tb/tb_sipo_shift_register.sv
// tb_sipo_shift_register: directed checks of left/right 4-bit and 8-bit shifter instances
module tb_sipo_shift_register;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rl, dl, sol, fl;
  logic [3:0] ql;
  logic [2:0] cl;
  logic       rr, dr, sor, fr;
  logic [3:0] qr;
  logic [2:0] cr;
  logic       r8, d8, so8, f8;
  logic [7:0] q8;
  logic [3:0] c8;
  sipo_shift_register #(.WIDTH(4), .SHIFT_LEFT(1'b1)) u_l (
    .CLK(clk), .Reset(rl), .D(dl), .Q(ql), .SO(sol), .Full(fl), .Count(cl));
  sipo_shift_register #(.WIDTH(4), .SHIFT_LEFT(1'b0)) u_r (
    .CLK(clk), .Reset(rr), .D(dr), .Q(qr), .SO(sor), .Full(fr), .Count(cr));
  sipo_shift_register #(.WIDTH(8), .SHIFT_LEFT(1'b1)) u_8 (
    .CLK(clk), .Reset(r8), .D(d8), .Q(q8), .SO(so8), .Full(f8), .Count(c8));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  typedef struct packed {
    logic       rst;
    logic       d;
    logic [3:0] q;
    logic       so;
    logic [2:0] cnt;
    logic       full;
  } vec_t;
  vec_t v [13];
  logic [7:0] word;
  logic [3:0] rq [4];
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    rl = 1'b0; dl = 1'b0; rr = 1'b0; dr = 1'b0; r8 = 1'b0; d8 = 1'b0;
    v[0]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0};
    v[1]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 3'd1, 1'b0};
    v[2]  = '{1'b1, 1'b0, 4'b0010, 1'b0, 3'd2, 1'b0};
    v[3]  = '{1'b1, 1'b1, 4'b0101, 1'b0, 3'd3, 1'b0};
    v[4]  = '{1'b1, 1'b1, 4'b1011, 1'b0, 3'd4, 1'b1};
    v[5]  = '{1'b1, 1'b0, 4'b0110, 1'b1, 3'd4, 1'b1};
    v[6]  = '{1'b1, 1'b1, 4'b1101, 1'b0, 3'd4, 1'b1};
    v[7]  = '{1'b1, 1'b1, 4'b1011, 1'b1, 3'd4, 1'b1};
    v[8]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0};
    v[9]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 3'd1, 1'b0};
    v[10] = '{1'b1, 1'b0, 4'b0010, 1'b0, 3'd2, 1'b0};
    v[11] = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0};
    v[12] = '{1'b1, 1'b1, 4'b0001, 1'b0, 3'd1, 1'b0};
    tick;
    for (int i = 0; i < 13; i++) begin
      rl = v[i].rst;
      dl = v[i].d;
      tick;
      chk($sformatf("left_q[%0d]", i), 32'(ql), 32'(v[i].q));
      chk($sformatf("left_so[%0d]", i), 32'(sol), 32'(v[i].so));
      chk($sformatf("left_cnt[%0d]", i), 32'(cl), 32'(v[i].cnt));
      chk($sformatf("left_full[%0d]", i), 32'(fl), 32'(v[i].full));
    end
    rr = 1'b0; dr = 1'b1;
    tick;
    chk("right_reset_q", 32'(qr), 32'h0);
    rr = 1'b1;
    rq[0] = 4'b1000; rq[1] = 4'b0100; rq[2] = 4'b1010; rq[3] = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      dr = (i == 1) ? 1'b0 : 1'b1;
      tick;
      chk($sformatf("right_q[%0d]", i), 32'(qr), 32'(rq[i]));
      chk($sformatf("right_so[%0d]", i), 32'(sor), 32'h0);
      chk($sformatf("right_full[%0d]", i), 32'(fr), (i == 3) ? 32'h1 : 32'h0);
    end
    dr = 1'b0;
    tick;
    chk("right_shift_q", 32'(qr), 32'b0110);
    chk("right_shift_so", 32'(sor), 32'h1);
    chk("right_sat_cnt", 32'(cr), 32'h4);
    r8 = 1'b0;
    tick;
    chk("w8_reset_q", 32'(q8), 32'h0);
    r8 = 1'b1;
    word = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      d8 = word[i];
      tick;
      chk($sformatf("w8_full[%0d]", 7 - i), 32'(f8), (i == 0) ? 32'h1 : 32'h0);
      chk($sformatf("w8_cnt[%0d]", 7 - i), 32'(c8), 32'(8 - i));
    end
    chk("w8_word", 32'(q8), 32'hA5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
